// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the ram_responder memory slave.
// Access-direction and access-size encodings match the READ_WRITE / WORD_BYTE pins.
package ram_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic ACC_READ  = 1'b1;
    localparam logic ACC_WRITE = 1'b0;
    localparam logic ACC_WORD  = 1'b1;
    localparam logic ACC_BYTE  = 1'b0;

    // Byte-lane write enables for a word access or a single-byte access at lane.
    function automatic logic [3:0] lane_mask(input logic word, input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0001 << lane;
        if (word == ACC_WORD) begin
            mask = 4'hF;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_responder_array.sv
// Synchronous 32-bit word array with per-byte write enables and a registered read port.
// Contents are deliberately never reset.
module ram_responder_array #(
    parameter int unsigned WORD_AW = 8
) (
    input  logic               clk_i,
    input  logic [3:0]         we_i,
    input  logic [WORD_AW-1:0] waddr_i,
    input  logic [31:0]        wdata_i,
    input  logic [WORD_AW-1:0] raddr_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] mem [0:(1 << WORD_AW) - 1];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/ram_responder.sv
// Four-phase (MFA/MFC) memory slave with fixed wait states over a byte-lane word array.
// Define RAM_RESPONDER_ALIGN_CHECK_EN to flag misaligned word accesses on ERR.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        READ_WRITE,
    input  logic        WORD_BYTE,
    input  logic [31:0] MEMADD,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MFC,
    output logic        ERR
);

    localparam int unsigned WORD_AW = ADDR_W - 2;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic                wb_q, wb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         dout_q, dout_d;
    logic                err_q, err_d;

    logic                final_edge;
    logic                misalign;
    logic [3:0]          we;
    logic [31:0]         wr_word;
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [WORD_AW-1:0]  raddr;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^MEMADD[31:ADDR_W];

`ifdef RAM_RESPONDER_ALIGN_CHECK_EN
    assign misalign = (wb_q == ACC_WORD) && (addr_q[1:0] != 2'b00);
    assign ERR      = err_q;
`else
    logic unused_err;
    assign misalign   = 1'b0;
    assign unused_err = err_q;
    assign ERR        = 1'b0;
`endif

    assign final_edge = (state_q == StBusy) && (cnt_q == 4'd0);
    assign MFC        = (state_q == StDone);
    assign DATA_OUT   = dout_q;

    // Read address comes straight from MEMADD while idle so the registered read
    // port has data ready even with zero wait states.
    assign raddr = (state_q == StIdle) ? MEMADD[ADDR_W-1:2] : addr_q[ADDR_W-1:2];

    assign wr_word = (wb_q == ACC_WORD) ? wdata_q : {4{wdata_q[7:0]}};
    assign we      = (Reset && final_edge && (rw_q == ACC_WRITE) && !misalign)
                   ? lane_mask(wb_q, addr_q[1:0]) : 4'b0000;

    always_comb begin
        rd_byte = rd_word[7:0];
        unique case (addr_q[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    ram_responder_array #(
        .WORD_AW (WORD_AW)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (we),
        .waddr_i (addr_q[ADDR_W-1:2]),
        .wdata_i (wr_word),
        .raddr_i (raddr),
        .rdata_o (rd_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        wb_d    = wb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (MFA) begin
                    state_d = StBusy;
                    cnt_d   = 4'(WAIT_CYCLES);
                    rw_d    = READ_WRITE;
                    wb_d    = WORD_BYTE;
                    addr_d  = MEMADD[ADDR_W-1:0];
                    wdata_d = DATA_IN;
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StDone;
                    err_d   = misalign;
                    if (misalign) begin
                        dout_d = 32'h0;
                    end else if (rw_q == ACC_READ) begin
                        dout_d = (wb_q == ACC_WORD) ? rd_word : {24'h0, rd_byte};
                    end
                end
            end
            StDone: begin
                if (!MFA) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rw_q    <= ACC_READ;
            wb_q    <= ACC_WORD;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            wb_q    <= wb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (ADDR_W=10, WAIT_CYCLES=2).
// Alignment expectations follow RAM_RESPONDER_ALIGN_CHECK_EN.
module tb_ram_responder;

    logic        clk;
    logic        reset_n;
    logic        mfa;
    logic        read_write;
    logic        word_byte;
    logic [31:0] memadd;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mfc;
    logic        err;

    int          n_checks;
    int          n_pass;
    logic [31:0] last_data;
    logic        last_err;
    int          last_lat;

    ram_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (2)
    ) dut (
        .Clk        (clk),
        .Reset      (reset_n),
        .MFA        (mfa),
        .READ_WRITE (read_write),
        .WORD_BYTE  (word_byte),
        .MEMADD     (memadd),
        .DATA_IN    (data_in),
        .DATA_OUT   (data_out),
        .MFC        (mfc),
        .ERR        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One full handshake; MFA is held for `hold` cycles after MFC before release.
    task automatic access(input logic rw, input logic wb, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        bit got;
        int held;
        @(negedge clk);
        mfa        = 1'b1;
        read_write = rw;
        word_byte  = wb;
        memadd     = addr;
        data_in    = wd;
        @(posedge clk);
        last_lat = 0;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            last_lat++;
            got = mfc;
        end
        if (!got) check("mfc_timeout", 32'd0, 32'd1);
        last_data = data_out;
        last_err  = err;
        held      = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (mfc && data_out === last_data) held++;
        end
        check("mfc_hold", held, hold);
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk);
        #1;
        check("mfc_fall", {31'd0, mfc}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        mfa        = 1'b1;
        read_write = 1'b1;
        word_byte  = 1'b1;
        memadd     = 32'h0;
        data_in    = 32'h0;

        // Reset dominates a held MFA.
        repeat (3) @(posedge clk);
        #1;
        check("rst_mfc", {31'd0, mfc}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_dout", data_out, 32'h0);
        @(negedge clk);
        mfa     = 1'b0;
        reset_n = 1'b1;

        // Word write then read, with latency.
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        check("wr_lat", last_lat, 3);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0);
        check("rd_lat", last_lat, 3);
        check("rd_word", last_data, 32'hDEADBEEF);
        check("rd_err", {31'd0, last_err}, 32'd0);

        // Byte lanes.
        access(1'b0, 1'b1, 32'h20, 32'h11223344, 0);
        access(1'b0, 1'b0, 32'h22, 32'h123456AA, 0);
        access(1'b1, 1'b1, 32'h20, 32'h0, 0);
        check("lane_word", last_data, 32'h11AA3344);
        access(1'b1, 1'b0, 32'h23, 32'h0, 0);
        check("lane_b3", last_data, 32'h00000011);
        access(1'b0, 1'b0, 32'h21, 32'h00000077, 0);
        check("wr_holds_dout", last_data, 32'h00000011);
        access(1'b1, 1'b0, 32'h20, 32'h0, 0);
        check("lane_b0", last_data, 32'h00000044);
        access(1'b1, 1'b1, 32'h20, 32'h0, 0);
        check("lane_word2", last_data, 32'h11AA7744);

        // Long MFA hold after MFC.
        access(1'b1, 1'b1, 32'h10, 32'h0, 10);
        check("hold_data", last_data, 32'hDEADBEEF);

        // MFA pulse with inputs scrambled during BUSY.
        @(negedge clk);
        mfa        = 1'b1;
        read_write = 1'b1;
        word_byte  = 1'b1;
        memadd     = 32'h20;
        @(posedge clk);
        @(negedge clk);
        mfa        = 1'b0;
        read_write = 1'b0;
        word_byte  = 1'b0;
        memadd     = 32'h10;
        data_in    = 32'h0;
        highs      = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (mfc) begin
                highs++;
                last_data = data_out;
            end
        end
        check("pulse_mfc_cycles", highs, 1);
        check("pulse_data", last_data, 32'h11AA7744);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0);
        check("pulse_no_write", last_data, 32'hDEADBEEF);

        // Reset at the second BUSY edge discards a pending write.
        access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 0);
        @(negedge clk);
        mfa        = 1'b1;
        read_write = 1'b0;
        word_byte  = 1'b1;
        memadd     = 32'h40;
        data_in    = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_mfc", {31'd0, mfc}, 32'd0);
        check("midrst_dout", data_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_idle", {31'd0, mfc}, 32'd0);
        access(1'b1, 1'b1, 32'h40, 32'h0, 0);
        check("midrst_kept", last_data, 32'hCAFEF00D);
        access(1'b1, 1'b1, 32'h10, 32'h0, 0);
        check("rst_keeps_mem", last_data, 32'hDEADBEEF);

        // Address wrap and alignment.
        access(1'b0, 1'b1, 32'h404, 32'h12345678, 0);
        access(1'b1, 1'b1, 32'h004, 32'h0, 0);
        check("wrap_rd", last_data, 32'h12345678);
        access(1'b1, 1'b1, 32'hFFFFFC04, 32'h0, 0);
        check("wrap_hi_rd", last_data, 32'h12345678);
        check("wrap_err", {31'd0, last_err}, 32'd0);
        access(1'b1, 1'b1, 32'h006, 32'h0, 0);
`ifdef RAM_RESPONDER_ALIGN_CHECK_EN
        check("misalign_err", {31'd0, last_err}, 32'd1);
        check("misalign_dout", last_data, 32'h0);
        access(1'b0, 1'b1, 32'h005, 32'hFFFFFFFF, 0);
        access(1'b1, 1'b1, 32'h004, 32'h0, 0);
        check("misalign_no_wr", last_data, 32'h12345678);
`else
        check("misalign_err", {31'd0, last_err}, 32'd0);
        check("misalign_dout", last_data, 32'h12345678);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
